arbitro_escrita_reg: RTL and testbench
======================================

Name: arbitro_escrita_reg

Overview:
- Sequences the single write port of the 32x64-bit register file.
- After reset, clears every register to 0, one per cycle.
- Then arbitrates, round-robin, between two writeback requesters: A = ULA result, B = memory/load result. Each uses a valid/ready handshake.
- Sits between the writeback stage and the register file. Drives rf_we, the destination address and the write data through a single registered output stage.

Parameters:
- XLEN, 64, data width of the register file.
- NREG, 32, number of registers. Address width AW = clog2(NREG).
- LIMPAR_INICIO, 1, when 1 run the clear sequence after reset; when 0 go directly to OPERANDO.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A has a write pending.
- a_ready  out  1  A's write accepted this cycle.
- a_endereco  in  AW  A's destination register.
- a_dado  in  XLEN  A's write data.
- b_valid, b_ready, b_endereco, b_dado: same as the A ports, for requester B.
- rf_we  out  1  register file write enable.
- rf_endereco  out  AW  register file destination address.
- rf_dado  out  XLEN  register file write data.
- ocupado  out  1  high while clearing; requesters are stalled.

Behaviour:
- Clock and reset: clk is the only clock. reset_n is asynchronous, active-low.
- Values while reset_n=0:
  - rf_we=0, rf_endereco=0, rf_dado=0.
  - ocupado=1 if LIMPAR_INICIO=1, else 0.
  - State = LIMPANDO (or OPERANDO if LIMPAR_INICIO=0).
  - Clear counter = 1.
  - Round-robin priority = A.
- FSM, two states:
  - LIMPANDO: each cycle, register rf_we=1, rf_endereco=counter, rf_dado=0, then increment counter. After the write to NREG-1 is registered, go to OPERANDO.
    - Exactly NREG-1 clear writes (registers 1..31); register 0 is never written.
    - ocupado=1 throughout LIMPANDO. ocupado falls on the same edge that enters OPERANDO.
    - a_ready=b_ready=0 in LIMPANDO.
  - OPERANDO: stays here until reset.
- Arbitration in OPERANDO (combinational ready, registered output):
  - Only A valid: a_ready=1. Only B valid: b_ready=1.
  - Both valid: the requester holding priority gets ready=1; the other gets ready=0 and must hold its valid and payload stable.
  - A ready may depend on valid; valid must never depend on ready.
  - On a completed handshake, priority moves to the other requester. With no handshake, priority is unchanged.
- Output stage:
  - Handshake on edge N: rf_we, rf_endereco, rf_dado show the winner's request during cycle N+1. Latency is 1 cycle.
  - Throughput is 1 write per cycle. No backpressure from the register file.
  - No handshake on edge N: rf_we=0 in cycle N+1; rf_endereco and rf_dado hold their previous values.
- x0 writes:
  - A handshake with endereco=0 completes normally and rotates priority.
  - rf_we stays 0 for that write; rf_endereco and rf_dado are still updated.
- Reset mid-clear or mid-operation: all state returns to reset values immediately. Clearing restarts from register 1. Any request accepted in the cycle reset asserts is dropped.
- Width rules: the clear counter is AW+1 bits, so it never wraps before the termination compare. Data passes through unmodified.

Decomposition:
- Shared package holds:
  - state encoding: LIMPANDO=1'b0, OPERANDO=1'b1;
  - XLEN and NREG defaults;
  - the requester index constants REQ_A=0, REQ_B=1.
- The round-robin grant logic is a natural sub-module: arbitro_rr2.
  - Inputs: valid[1:0], handshake, clk, reset_n.
  - Outputs: grant[1:0], priority flag.
- Everything else stays in this block.

Test Plan:
- Clear sequence: release reset with no requests. Expected: ocupado=1 for 31 cycles; rf_we=1 with rf_endereco 1,2,...,31 and rf_dado=0 on consecutive cycles; then ocupado=0 and rf_we=0. Checking through banco_reg: register 5 reads 0.
- Single requester: after clearing, a_valid=1, a_endereco=7, a_dado=64'hDEAD_BEEF for 1 cycle. Expected: a_ready=1 that cycle; next cycle rf_we=1, rf_endereco=7, rf_dado=64'hDEAD_BEEF; then rf_we=0.
- Contention and round-robin: A (addr 3, data 0x11) and B (addr 4, data 0x22) both hold valid for 4 cycles, each re-presenting after acceptance. Expected: grants A, B, A, B; rf_endereco sequence 3, 4, 3, 4, one per cycle; the losing requester's payload stays stable while it waits.
- x0 suppression: b_valid=1, b_endereco=0, b_dado=0xFF. Expected: b_ready=1; rf_we stays 0 next cycle; priority flips to A, so with both valid next, A wins.
- Requests during clearing: a_valid=1 from reset release. Expected: a_ready=0 for 31 cycles; accepted on the first OPERANDO cycle; written one cycle later.
- Reset mid-operation: assert reset_n=0 asynchronously (between edges) while B is being granted, then release. Expected: rf_we drops to 0 immediately; ocupado=1; clearing restarts at rf_endereco=1; the B write never appears.

Source files
------------

// File: rtl/arbitro_escrita_reg_pkg.sv
// arbitro_escrita_reg_pkg
// Shared definitions for the register-file write sequencer:
//   - estado_t     : sequencer states (LIMPANDO clears the file, OPERANDO arbitrates)
//   - XLEN_PADRAO  : default data width of the register file
//   - NREG_PADRAO  : default number of registers
//   - REQ_A/REQ_B  : bit index of each requester inside valid/grant vectors
package arbitro_escrita_reg_pkg;

  typedef enum logic {
    LIMPANDO = 1'b0,
    OPERANDO = 1'b1
  } estado_t;

  localparam int XLEN_PADRAO = 64;
  localparam int NREG_PADRAO = 32;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

endpackage

// File: rtl/arbitro_rr2.sv
// arbitro_rr2
// Two-way round-robin grant generator.
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset (priority returns to A)
//   valid[1:0] in   pending requests, indexed by REQ_A / REQ_B
//   handshake  in   a grant was consumed this cycle
//   grant[1:0] out  one-hot (or zero) combinational grant
//   prioridade out  0 = A wins a tie, 1 = B wins a tie
module arbitro_rr2
  import arbitro_escrita_reg_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       handshake,
  output logic [1:0] grant,
  output logic       prioridade
);

  always_comb begin
    grant = 2'b00;
    if (valid[REQ_A] && (!valid[REQ_B] || !prioridade)) begin
      grant[REQ_A] = 1'b1;
    end else if (valid[REQ_B]) begin
      grant[REQ_B] = 1'b1;
    end
  end

  // After a completed handshake the tie goes to whoever did not just win.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prioridade <= 1'b0;
    end else if (handshake) begin
      prioridade <= grant[REQ_A];
    end
  end

endmodule

// File: rtl/arbitro_escrita_reg.sv
// arbitro_escrita_reg
// Sequences the single write port of the register file. After reset it
// clears registers 1..NREG-1 (one per cycle), then arbitrates round-robin
// between the ALU writeback (A) and the load writeback (B).
// Ports:
//   clk, reset_n                        clock / asynchronous active-low reset
//   a_valid, a_endereco, a_dado, a_ready  requester A handshake and payload
//   b_valid, b_endereco, b_dado, b_ready  requester B handshake and payload
//   rf_we, rf_endereco, rf_dado         registered register-file write port
//   ocupado                             high while clearing (requesters stalled)
module arbitro_escrita_reg
  import arbitro_escrita_reg_pkg::*;
#(
  parameter int XLEN          = XLEN_PADRAO,
  parameter int NREG          = NREG_PADRAO,
  parameter bit LIMPAR_INICIO = 1'b1,
  localparam int AW           = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_endereco,
  input  logic [XLEN-1:0] a_dado,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_endereco,
  input  logic [XLEN-1:0] b_dado,
  output logic            rf_we,
  output logic [AW-1:0]   rf_endereco,
  output logic [XLEN-1:0] rf_dado,
  output logic            ocupado
);

  localparam int AW1 = AW + 1;
  // The counter carries one extra bit so the last-register compare happens
  // before any wrap could occur.
  localparam logic [AW:0] ULTIMO = AW1'(NREG - 1);
  localparam estado_t ESTADO_INICIAL = LIMPAR_INICIO ? LIMPANDO : OPERANDO;

  estado_t         estado;
  logic [AW:0]     contador;
  logic [1:0]      valid_efetivo;
  logic [1:0]      grant;
  logic            handshake;
  logic            prioridade;
  logic            seleciona_b;
  logic [AW-1:0]   endereco_vencedor;
  logic [XLEN-1:0] dado_vencedor;

  // Requesters are invisible to the arbiter until clearing has finished.
  assign valid_efetivo = (estado == OPERANDO) ? {b_valid, a_valid} : 2'b00;
  assign handshake     = |grant;
  assign a_ready       = grant[REQ_A];
  assign b_ready       = grant[REQ_B];
  assign ocupado       = (estado == LIMPANDO);

  arbitro_rr2 u_rr (
    .clk        (clk),
    .reset_n    (reset_n),
    .valid      (valid_efetivo),
    .handshake  (handshake),
    .grant      (grant),
    .prioridade (prioridade)
  );

  // Payload mux: B is selected when it is the only candidate or holds the
  // tie-break; the write itself is qualified by handshake below.
  assign seleciona_b       = valid_efetivo[REQ_B] & (~valid_efetivo[REQ_A] | prioridade);
  assign endereco_vencedor = seleciona_b ? b_endereco : a_endereco;
  assign dado_vencedor     = seleciona_b ? b_dado : a_dado;

  // Single registered output stage shared by the clear sequence and the
  // arbitrated writes. Writes to x0 update address/data but keep rf_we low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado      <= ESTADO_INICIAL;
      contador    <= AW1'(1);
      rf_we       <= 1'b0;
      rf_endereco <= '0;
      rf_dado     <= '0;
    end else begin
      case (estado)
        LIMPANDO: begin
          rf_we       <= 1'b1;
          rf_endereco <= contador[AW-1:0];
          rf_dado     <= '0;
          contador    <= contador + AW1'(1);
          if (contador == ULTIMO) begin
            estado <= OPERANDO;
          end
        end
        OPERANDO: begin
          rf_we <= handshake && (endereco_vencedor != '0);
          if (handshake) begin
            rf_endereco <= endereco_vencedor;
            rf_dado     <= dado_vencedor;
          end
        end
        default: begin
          estado <= ESTADO_INICIAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_escrita_reg.sv
// tb_arbitro_escrita_reg
// Self-checking bench for arbitro_escrita_reg: directed scenarios followed
// by randomized traffic compared against a transaction-level model that
// tracks pending requests, tie-break owner and the expected write port.
module tb_arbitro_escrita_reg;
  import arbitro_escrita_reg_pkg::*;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            a_valid = 1'b0, b_valid = 1'b0;
  logic            a_ready, b_ready;
  logic [AW-1:0]   a_endereco = '0, b_endereco = '0;
  logic [XLEN-1:0] a_dado = '0, b_dado = '0;
  logic            rf_we;
  logic [AW-1:0]   rf_endereco;
  logic [XLEN-1:0] rf_dado;
  logic            ocupado;

  int erros  = 0;
  int checks = 0;
  int prio_modelo = 0;  // 0: A wins a tie, 1: B wins a tie

  logic [XLEN-1:0] banco [NREG];

  always #5 clk = ~clk;

  arbitro_escrita_reg #(.XLEN(XLEN), .NREG(NREG), .LIMPAR_INICIO(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_endereco(a_endereco), .a_dado(a_dado),
    .b_valid(b_valid), .b_ready(b_ready), .b_endereco(b_endereco), .b_dado(b_dado),
    .rf_we(rf_we), .rf_endereco(rf_endereco), .rf_dado(rf_dado), .ocupado(ocupado)
  );

  // Register file model fed by the DUT write port.
  always @(posedge clk) begin
    if (rf_we) banco[rf_endereco] <= rf_dado;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic aplica_reset();
    reset_n = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (3) @(negedge clk);
    prio_modelo = 0;
  endtask

  task automatic test_reset();
    aplica_reset();
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0) begin erros++; $display("[TB] FAIL reset_rf_we: got %0b expected 0", rf_we); end
    checks++; if (rf_endereco !== 5'd0) begin erros++; $display("[TB] FAIL reset_rf_endereco: got %0d expected 0", rf_endereco); end
    checks++; if (rf_dado !== 64'd0) begin erros++; $display("[TB] FAIL reset_rf_dado: got %0h expected 0", rf_dado); end
    checks++; if (ocupado !== 1'b1) begin erros++; $display("[TB] FAIL reset_ocupado: got %0b expected 1", ocupado); end
    checks++; if ({a_ready, b_ready} !== 2'b00) begin erros++; $display("[TB] FAIL reset_ready: got %b expected 00", {a_ready, b_ready}); end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_clear();
    int zeros_ok;
    reset_n = 1'b1;
    for (int i = 1; i <= NREG - 1; i++) begin
      #1;
      checks++; if (ocupado !== 1'b1) begin erros++; $display("[TB] FAIL clear_ocupado[%0d]: got %0b expected 1", i, ocupado); end
      @(posedge clk); #1;
      checks++;
      if ({rf_we, rf_endereco, rf_dado} !== {1'b1, 5'(i), 64'd0}) begin
        erros++;
        $display("[TB] FAIL clear_write[%0d]: got we=%0b addr=%0d data=%0h expected we=1 addr=%0d data=0", i, rf_we, rf_endereco, rf_dado, i);
      end
      @(negedge clk);
    end
    #1;
    checks++; if (ocupado !== 1'b0) begin erros++; $display("[TB] FAIL clear_end_ocupado: got %0b expected 0", ocupado); end
    @(posedge clk); #1;
    checks++; if (rf_we !== 1'b0) begin erros++; $display("[TB] FAIL clear_end_we: got %0b expected 0", rf_we); end
    @(negedge clk);
    checks++; if (banco[5] !== 64'd0) begin erros++; $display("[TB] FAIL clear_reg5: got %0h expected 0", banco[5]); end
    zeros_ok = 1;
    for (int r = 1; r < NREG; r++) if (banco[r] !== 64'd0) zeros_ok = 0;
    checks++; if (zeros_ok != 1) begin erros++; $display("[TB] FAIL clear_all_regs: got nonzero register expected all 0"); end
  endtask

  task automatic test_single();
    a_valid = 1'b1; a_endereco = 5'd7; a_dado = 64'hDEAD_BEEF;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin erros++; $display("[TB] FAIL single_ready: got %b expected 10", {a_ready, b_ready}); end
    @(posedge clk); #1;
    prio_modelo = 1;
    checks++;
    if ({rf_we, rf_endereco, rf_dado} !== {1'b1, 5'd7, 64'hDEAD_BEEF}) begin
      erros++; $display("[TB] FAIL single_write: got we=%0b addr=%0d data=%0h expected we=1 addr=7 data=deadbeef", rf_we, rf_endereco, rf_dado);
    end
    @(negedge clk);
    a_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rf_we, rf_endereco, rf_dado} !== {1'b0, 5'd7, 64'hDEAD_BEEF}) begin
      erros++; $display("[TB] FAIL single_idle: got we=%0b addr=%0d data=%0h expected we=0 addr=7 data=deadbeef", rf_we, rf_endereco, rf_dado);
    end
    @(negedge clk);
  endtask

  task automatic test_x0();
    b_valid = 1'b1; b_endereco = 5'd0; b_dado = 64'hFF;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b01) begin erros++; $display("[TB] FAIL x0_ready: got %b expected 01", {a_ready, b_ready}); end
    @(posedge clk); #1;
    prio_modelo = 0;
    checks++;
    if ({rf_we, rf_endereco, rf_dado} !== {1'b0, 5'd0, 64'hFF}) begin
      erros++; $display("[TB] FAIL x0_write: got we=%0b addr=%0d data=%0h expected we=0 addr=0 data=ff", rf_we, rf_endereco, rf_dado);
    end
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic test_contention();
    int seq_end [4] = '{3, 4, 3, 4};
    logic vence_a;
    a_valid = 1'b1; a_endereco = 5'd3; a_dado = 64'h11;
    b_valid = 1'b1; b_endereco = 5'd4; b_dado = 64'h22;
    for (int k = 0; k < 4; k++) begin
      vence_a = (seq_end[k] == 3);
      #1;
      checks++;
      if ({a_ready, b_ready} !== {vence_a, ~vence_a}) begin
        erros++; $display("[TB] FAIL contention_grant[%0d]: got %b expected %b", k, {a_ready, b_ready}, {vence_a, ~vence_a});
      end
      @(posedge clk); #1;
      checks++;
      if ({rf_we, rf_endereco, rf_dado} !== {1'b1, 5'(seq_end[k]), (vence_a ? 64'h11 : 64'h22)}) begin
        erros++; $display("[TB] FAIL contention_write[%0d]: got we=%0b addr=%0d data=%0h expected addr=%0d", k, rf_we, rf_endereco, rf_dado, seq_end[k]);
      end
      @(negedge clk);
    end
    prio_modelo = 0;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_during_clear();
    logic [XLEN-1:0] d;
    d = {$urandom, $urandom};
    aplica_reset();
    a_valid = 1'b1; a_endereco = 5'd9; a_dado = d;
    reset_n = 1'b1;
    for (int i = 1; i <= NREG - 1; i++) begin
      #1;
      checks++; if (a_ready !== 1'b0) begin erros++; $display("[TB] FAIL during_clear_ready[%0d]: got %0b expected 0", i, a_ready); end
      @(posedge clk); #1;
      checks++; if (rf_endereco !== 5'(i)) begin erros++; $display("[TB] FAIL during_clear_addr[%0d]: got %0d expected %0d", i, rf_endereco, i); end
      @(negedge clk);
    end
    #1;
    checks++; if (a_ready !== 1'b1) begin erros++; $display("[TB] FAIL during_clear_accept: got %0b expected 1", a_ready); end
    @(posedge clk); #1;
    prio_modelo = 1;
    checks++;
    if ({rf_we, rf_endereco, rf_dado} !== {1'b1, 5'd9, d}) begin
      erros++; $display("[TB] FAIL during_clear_write: got we=%0b addr=%0d data=%0h expected we=1 addr=9 data=%0h", rf_we, rf_endereco, rf_dado, d);
    end
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_valid = 1'b1; a_endereco = 5'd2; a_dado = 64'h1234;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b1; b_endereco = 5'd12; b_dado = {$urandom, $urandom} | 64'h1;
    #1;
    checks++; if (b_ready !== 1'b1) begin erros++; $display("[TB] FAIL reset_mid_grant: got %0b expected 1", b_ready); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rf_we, ocupado, rf_endereco} !== {1'b0, 1'b1, 5'd0}) begin
      erros++; $display("[TB] FAIL reset_mid_async: got we=%0b ocupado=%0b addr=%0d expected we=0 ocupado=1 addr=0", rf_we, ocupado, rf_endereco);
    end
    b_valid = 1'b0;
    @(negedge clk);
    prio_modelo = 0;
    reset_n = 1'b1;
    for (int i = 1; i <= NREG - 1; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({rf_we, rf_endereco, rf_dado} !== {1'b1, 5'(i), 64'd0}) begin
        erros++; $display("[TB] FAIL reset_mid_clear[%0d]: got we=%0b addr=%0d data=%0h expected we=1 addr=%0d data=0", i, rf_we, rf_endereco, rf_dado, i);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic            pend_a, pend_b, acc_a, acc_b, exp_we;
    logic [AW-1:0]   exp_end;
    logic [XLEN-1:0] exp_dado;
    pend_a = 1'b0; pend_b = 1'b0;
    exp_end = 5'd31; exp_dado = 64'd0;
    for (int c = 0; c < 400; c++) begin
      if (!pend_a && $urandom_range(0, 2) != 0) begin
        pend_a = 1'b1; a_endereco = 5'($urandom_range(0, 31)); a_dado = {$urandom, $urandom};
      end
      if (!pend_b && $urandom_range(0, 2) != 0) begin
        pend_b = 1'b1; b_endereco = 5'($urandom_range(0, 31)); b_dado = {$urandom, $urandom};
      end
      a_valid = pend_a;
      b_valid = pend_b;
      acc_a = pend_a && (!pend_b || prio_modelo == 0);
      acc_b = pend_b && !acc_a;
      #1;
      checks++;
      if ({a_ready, b_ready} !== {acc_a, acc_b}) begin
        erros++; $display("[TB] FAIL random_ready[%0d]: got %b expected %b", c, {a_ready, b_ready}, {acc_a, acc_b});
      end
      exp_we = 1'b0;
      if (acc_a) begin exp_end = a_endereco; exp_dado = a_dado; exp_we = (a_endereco != 0); prio_modelo = 1; pend_a = 1'b0; end
      if (acc_b) begin exp_end = b_endereco; exp_dado = b_dado; exp_we = (b_endereco != 0); prio_modelo = 0; pend_b = 1'b0; end
      @(posedge clk); #1;
      checks++;
      if ({rf_we, rf_endereco, rf_dado} !== {exp_we, exp_end, exp_dado}) begin
        erros++; $display("[TB] FAIL random_write[%0d]: got we=%0b addr=%0d data=%0h expected we=%0b addr=%0d data=%0h", c, rf_we, rf_endereco, rf_dado, exp_we, exp_end, exp_dado);
      end
      @(negedge clk);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clear();
    test_single();
    test_x0();
    test_contention();
    test_during_clear();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end

endmodule
